testpat_sequencer: RTL and testbench

Drives a sequence of measurement runs on the `testpat` power-test pattern generator. For each run it issues a START pulse, holds for a programmed run window, issues a STOP pulse, waits for the elapsed-time counter (`Laikas`) to settle, and then captures it. It repeats this NUM_RUNS times and accumulates sum, minimum and maximum of the captured times. It sits between the host/control logic and `testpat`, taking over the START/STOP stimulus now hand-generated in simulation.

---
 rtl/testpat_seq_pkg.sv | 28 ++
 rtl/seq_timer.sv | 35 +++
 rtl/testpat_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_testpat_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/testpat_seq_pkg.sv
// Shared types and widths for the testpat measurement-run sequencer.
package testpat_seq_pkg;

  localparam int SUM_W     = 40;
  localparam int LAIKAS_W  = 32;
  localparam int RUN_IDX_W = 9;

  typedef enum logic [2:0] {
    IDLE,
    START_P,
    RUN,
    STOP_P,
    SETTLE,
    CAPTURE,
    GAP,
    FINISH
  } seq_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; zero flags the last cycle of a timed state.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/testpat_sequencer.sv
// Issues START/STOP pulse pairs to testpat, captures Laikas after each run and
// accumulates sum/min/max over NUM_RUNS runs.
module testpat_sequencer
  import testpat_seq_pkg::*;
#(
  parameter int PULSE_CYCLES  = 2,
  parameter int RUN_CYCLES    = 1000,
  parameter int SETTLE_CYCLES = 4,
  parameter int GAP_CYCLES    = 100,
  parameter int NUM_RUNS      = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic                 GO,
  input  logic                 ABORT,
  output logic                 START_OUT,
  output logic                 STOP_OUT,
  input  logic [LAIKAS_W-1:0]  LAIKAS_IN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ABORTED,
  output logic [RUN_IDX_W-1:0] RUN_IDX,
  output logic [SUM_W-1:0]     LAIKAS_SUM,
  output logic [LAIKAS_W-1:0]  LAIKAS_MIN,
  output logic [LAIKAS_W-1:0]  LAIKAS_MAX
);

  localparam int MAX_CYC = max4(PULSE_CYCLES, RUN_CYCLES, SETTLE_CYCLES, GAP_CYCLES);
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  // Timer counts down to zero, so each state loads its length minus one.
  localparam logic [TMR_W-1:0] P_LD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] R_LD = TMR_W'(RUN_CYCLES - 1);
  localparam logic [TMR_W-1:0] S_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] G_LD = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [RUN_IDX_W-1:0] RUNS = RUN_IDX_W'(NUM_RUNS);

  seq_state_e state_q, state_d;
  logic       abort_pend_q, abort_pend_d;
  logic       start_q, stop_q, busy_q, done_q, aborted_q;
  logic       aborted_d;
  logic       tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic       tmr_zero;
  logic       clear_stats;
  logic       capture;

  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [LAIKAS_W-1:0]  min_q, min_d;
  logic [LAIKAS_W-1:0]  max_q, max_d;
  logic [RUN_IDX_W-1:0] run_idx_q, run_idx_d;
  logic [RUN_IDX_W-1:0] run_inc;

  assign run_inc = run_idx_q + RUN_IDX_W'(1);

  seq_timer #(.W(TMR_W)) u_timer (
    .clk      (CLOCK_50),
    .rst_n    (RESET_N),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    clear_stats  = 1'b0;
    capture      = 1'b0;

    case (state_q)
      IDLE: begin
        abort_pend_d = 1'b0;
        if (GO && !ABORT) begin
          state_d     = START_P;
          tmr_load    = 1'b1;
          tmr_val     = P_LD;
          clear_stats = 1'b1;
        end
      end
      START_P, RUN: begin
        if (ABORT) begin
          // Always finish with a full STOP pulse so testpat is left stopped.
          state_d      = STOP_P;
          tmr_load     = 1'b1;
          tmr_val      = P_LD;
          abort_pend_d = 1'b1;
        end else if (tmr_zero) begin
          state_d  = (state_q == START_P) ? RUN : STOP_P;
          tmr_load = 1'b1;
          tmr_val  = (state_q == START_P) ? R_LD : P_LD;
        end
      end
      STOP_P: begin
        if (ABORT) abort_pend_d = 1'b1;
        if (tmr_zero) begin
          if (abort_pend_q || ABORT) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
          end else begin
            state_d  = SETTLE;
            tmr_load = 1'b1;
            tmr_val  = S_LD;
          end
        end
      end
      SETTLE: begin
        if (ABORT) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (tmr_zero) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        if (ABORT) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (run_inc == RUNS) begin
          state_d = FINISH;
        end else if (GAP_CYCLES == 0) begin
          state_d  = START_P;
          tmr_load = 1'b1;
          tmr_val  = P_LD;
        end else begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = G_LD;
        end
      end
      GAP: begin
        if (ABORT) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (tmr_zero) begin
          state_d  = START_P;
          tmr_load = 1'b1;
          tmr_val  = P_LD;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum_d     = sum_q;
    min_d     = min_q;
    max_d     = max_q;
    run_idx_d = run_idx_q;
    if (clear_stats) begin
      sum_d     = '0;
      min_d     = '1;
      max_d     = '0;
      run_idx_d = '0;
    end else if (capture) begin
      sum_d     = sum_q + SUM_W'(LAIKAS_IN);
      min_d     = (LAIKAS_IN < min_q) ? LAIKAS_IN : min_q;
      max_d     = (LAIKAS_IN > max_q) ? LAIKAS_IN : max_q;
      run_idx_d = run_inc;
    end
  end

  // Outputs are decoded from the next state so they are clean flop outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      abort_pend_q <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      sum_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      run_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      abort_pend_q <= abort_pend_d;
      start_q      <= (state_d == START_P);
      stop_q       <= (state_d == STOP_P);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == FINISH);
      aborted_q    <= aborted_d;
      sum_q        <= sum_d;
      min_q        <= min_d;
      max_q        <= max_d;
      run_idx_q    <= run_idx_d;
    end
  end

  assign START_OUT  = start_q;
  assign STOP_OUT   = stop_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ABORTED    = aborted_q;
  assign RUN_IDX    = run_idx_q;
  assign LAIKAS_SUM = sum_q;
  assign LAIKAS_MIN = min_q;
  assign LAIKAS_MAX = max_q;

endmodule

// File: tb/tb_testpat_sequencer.sv
// Directed bench for testpat_sequencer: nominal runs, aborts, ignored GO,
// async reset mid-run and a single-run edge-value instance.
module tb_testpat_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0, abort = 1'b0;
  logic [31:0] laikas = '0;
  logic        start_o, stop_o, busy, done, aborted;
  logic [8:0]  run_idx;
  logic [39:0] sum;
  logic [31:0] mn, mx;

  logic        go2 = 1'b0, abort2 = 1'b0;
  logic [31:0] laikas2 = 32'hFFFF_FFFF;
  logic        start2, stop2, busy2, done2, aborted2;
  logic [8:0]  run_idx2;
  logic [39:0] sum2;
  logic [31:0] mn2, mx2;

  int total = 0;
  int bad = 0;

  logic [127:0] start_v, stop_v, busy_v, done_v, abort_v;
  logic [39:0]  sum_at19;
  logic [31:0]  min_at19;
  logic [127:0] e_start, e_stop, e_busy, e_done, e_abort;
  logic [31:0]  vals [0:2];

  always #5 clk = ~clk;

  testpat_sequencer #(
    .PULSE_CYCLES(2), .RUN_CYCLES(10), .SETTLE_CYCLES(3), .GAP_CYCLES(5), .NUM_RUNS(3)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .GO(go), .ABORT(abort),
    .START_OUT(start_o), .STOP_OUT(stop_o), .LAIKAS_IN(laikas),
    .BUSY(busy), .DONE(done), .ABORTED(aborted), .RUN_IDX(run_idx),
    .LAIKAS_SUM(sum), .LAIKAS_MIN(mn), .LAIKAS_MAX(mx)
  );

  testpat_sequencer #(
    .PULSE_CYCLES(2), .RUN_CYCLES(10), .SETTLE_CYCLES(3), .GAP_CYCLES(0), .NUM_RUNS(1)
  ) dut2 (
    .CLOCK_50(clk), .RESET_N(rst_n), .GO(go2), .ABORT(abort2),
    .START_OUT(start2), .STOP_OUT(stop2), .LAIKAS_IN(laikas2),
    .BUSY(busy2), .DONE(done2), .ABORTED(aborted2), .RUN_IDX(run_idx2),
    .LAIKAS_SUM(sum2), .LAIKAS_MIN(mn2), .LAIKAS_MAX(mx2)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Pulses GO, then records ncyc cycles; cycle c is the c-th cycle after the GO edge.
  task automatic run_seq(input int ncyc, input int abort_at, input int go_again_at);
    start_v = '0; stop_v = '0; busy_v = '0; done_v = '0; abort_v = '0;
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      abort  = (c == abort_at);
      go     = (c == go_again_at);
      laikas = vals[((c - 1) / 23 > 2) ? 2 : (c - 1) / 23];
      start_v[c] = start_o;
      stop_v[c]  = stop_o;
      busy_v[c]  = busy;
      done_v[c]  = done;
      abort_v[c] = aborted;
      if (c == 19) begin
        sum_at19 = sum;
        min_at19 = mn;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    go    = 1'b0;
  endtask

  task automatic check_nominal(input string pfx);
    e_start = '0; e_stop = '0; e_busy = '0; e_done = '0; e_abort = '0;
    for (int k = 0; k < 3; k++) begin
      e_start[1 + 23*k]  = 1'b1;
      e_start[2 + 23*k]  = 1'b1;
      e_stop[13 + 23*k]  = 1'b1;
      e_stop[14 + 23*k]  = 1'b1;
    end
    for (int c = 1; c <= 65; c++) e_busy[c] = 1'b1;
    e_done[65] = 1'b1;
    check({pfx, "_start"}, start_v, e_start);
    check({pfx, "_stop"}, stop_v, e_stop);
    check({pfx, "_busy"}, busy_v, e_busy);
    check({pfx, "_done"}, done_v, e_done);
    check({pfx, "_aborted"}, abort_v, e_abort);
    check({pfx, "_sum19"}, 128'(sum_at19), 128'(100));
    check({pfx, "_min19"}, 128'(min_at19), 128'(100));
    check({pfx, "_sum"}, 128'(sum), 128'(310));
    check({pfx, "_min"}, 128'(mn), 128'(90));
    check({pfx, "_max"}, 128'(mx), 128'(120));
    check({pfx, "_runidx"}, 128'(run_idx), 128'(3));
  endtask

  initial begin
    vals[0] = 32'd100;
    vals[1] = 32'd90;
    vals[2] = 32'd120;

    // Reset state
    #12;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_start", 128'(start_o), 128'(0));
    check("rst_stop", 128'(stop_o), 128'(0));
    check("rst_done_aborted", 128'({done, aborted}), 128'(0));
    check("rst_runidx", 128'(run_idx), 128'(0));
    check("rst_sum", 128'(sum), 128'(0));
    check("rst_min", 128'(mn), 128'(0));
    check("rst_max", 128'(mx), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal, with a GO during a busy cycle that must be ignored
    run_seq(70, 0, 30);
    check_nominal("nom");

    // Abort in RUN
    run_seq(12, 5, 0);
    e_stop = '0; e_stop[6] = 1'b1; e_stop[7] = 1'b1;
    e_abort = '0; e_abort[8] = 1'b1;
    e_busy = '0; for (int c = 1; c <= 7; c++) e_busy[c] = 1'b1;
    check("arun_stop", stop_v, e_stop);
    check("arun_aborted", abort_v, e_abort);
    check("arun_busy", busy_v, e_busy);
    check("arun_done", done_v, 128'(0));
    check("arun_sum", 128'(sum), 128'(0));
    check("arun_runidx", 128'(run_idx), 128'(0));

    // Abort in GAP
    run_seq(25, 20, 0);
    e_abort = '0; e_abort[21] = 1'b1;
    e_busy = '0; for (int c = 1; c <= 20; c++) e_busy[c] = 1'b1;
    check("agap_aborted", abort_v, e_abort);
    check("agap_busy", busy_v, e_busy);
    check("agap_runidx", 128'(run_idx), 128'(1));
    check("agap_sum", 128'(sum), 128'(100));
    check("agap_minmax", 128'({mn, mx}), 128'({32'd100, 32'd100}));

    // GO and ABORT together in IDLE
    @(negedge clk); go = 1'b1; abort = 1'b1;
    @(negedge clk); go = 1'b0; abort = 1'b0;
    check("goab_busy", 128'(busy), 128'(0));
    check("goab_aborted", 128'(aborted), 128'(0));
    @(negedge clk);
    check("goab_busy_later", 128'(busy), 128'(0));
    check("goab_runidx_kept", 128'(run_idx), 128'(1));

    // Async reset while STOP_OUT is high (cycle t0+13)
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (12) @(negedge clk);
    check("rmid_stop_pre", 128'(stop_o), 128'(1));
    check("rmid_min_pre", 128'(mn), 128'(32'hFFFF_FFFF));
    #2 rst_n = 1'b0;
    #1;
    check("rmid_stop", 128'(stop_o), 128'(0));
    check("rmid_busy", 128'(busy), 128'(0));
    check("rmid_stats", 128'({sum, mn, mx, run_idx}), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_seq(70, 0, 0);
    check_nominal("rerun");

    // Single run, zero gap, all-ones Laikas
    start_v = '0; busy_v = '0; done_v = '0;
    @(negedge clk); go2 = 1'b1;
    @(negedge clk); go2 = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      start_v[c] = start2;
      busy_v[c]  = busy2;
      done_v[c]  = done2;
      @(negedge clk);
    end
    e_start = '0; e_start[1] = 1'b1; e_start[2] = 1'b1;
    e_busy = '0; for (int c = 1; c <= 19; c++) e_busy[c] = 1'b1;
    e_done = '0; e_done[19] = 1'b1;
    check("one_start", start_v, e_start);
    check("one_busy", busy_v, e_busy);
    check("one_done", done_v, e_done);
    check("one_sum", 128'(sum2), 128'(40'h00_FFFF_FFFF));
    check("one_minmax", 128'({mn2, mx2}), 128'({32'hFFFF_FFFF, 32'hFFFF_FFFF}));
    check("one_runidx", 128'(run_idx2), 128'(1));
    check("one_aborted", 128'(aborted2), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
